// File: rtl/audio_dma_wr_sched.sv
// Audio-to-host DMA write scheduler: packs L/R samples into 128-bit beats, buffers them,
// and emits BURST_BEATS-beat 3DW memory-write TLPs into a host ring buffer.
//
// state  | meaning
// S_IDLE | waiting for cfg_en and a full burst in the FIFO; cfg_en low clears datapath
// S_HDR  | header beat presented on the stream
// S_DATA | data beats presented from the FIFO head, one pop per handshake
module audio_dma_wr_sched #(
    parameter int SAMPLE_W    = 16,
    parameter int FIFO_DEPTH  = 64,
    parameter int BURST_BEATS = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cfg_en,
    input  logic [31:0]         cfg_base_addr,
    input  logic [15:0]         cfg_ring_beats,
    input  logic [7:0]          ep_bus_num,
    input  logic [4:0]          ep_dev_num,
    input  logic [SAMPLE_W-1:0] rx_data,
    input  logic                rx_l_vld,
    input  logic                rx_r_vld,
    input  logic                axis_slave2_tready,
    output logic                axis_slave2_tvalid,
    output logic [127:0]        axis_slave2_tdata,
    output logic                axis_slave2_tlast,
    output logic [15:0]         wr_ptr,
    output logic                wrap_irq,
    output logic                overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_C   = CW'(BURST_BEATS);
    localparam logic [15:0]   BURST_W   = 16'(BURST_BEATS);
    localparam logic [15:0]   LAST_IDX  = 16'(BURST_BEATS - 1);
    localparam logic [9:0]    LEN_DW    = 10'(BURST_BEATS * 4);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t         state;
    logic [15:0]    beat_cnt;
    logic [15:0]    ring_lat;
    logic [15:0]    ptr_next;

    logic [SAMPLE_W-1:0] hold_l;
    logic [1:0]     slot;
    logic [95:0]    acc;
    logic [31:0]    frame;
    logic           push;
    logic           do_push;
    logic           pop;
    logic           clr;
    logic [127:0]   push_data;

    logic [127:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_idx;
    logic [AW-1:0]  rd_idx;
    logic [CW-1:0]  count;

    assign clr       = (state == S_IDLE) && !cfg_en;
    assign frame     = {rx_data, hold_l};
    assign push      = rx_r_vld && !clr && (slot == 2'd3);
    assign push_data = {frame, acc};
    assign do_push   = push && ((count != DEPTH_C) || pop);
    assign pop       = (state == S_DATA) && axis_slave2_tvalid && axis_slave2_tready;
    assign ptr_next  = wr_ptr + BURST_W;

    // R strobe completes a frame; an L strobe in the same cycle is ignored
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_l <= '0;
            slot   <= '0;
            acc    <= '0;
        end else if (clr) begin
            hold_l <= '0;
            slot   <= '0;
            acc    <= '0;
        end else if (rx_r_vld) begin
            case (slot)
                2'd0:    acc[31:0]  <= frame;
                2'd1:    acc[63:32] <= frame;
                2'd2:    acc[95:64] <= frame;
                default: ;
            endcase
            slot <= slot + 2'd1;
        end else if (rx_l_vld) begin
            hold_l <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= push_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && !do_push) overflow <= 1'b1;
            if (do_push) wr_idx <= wr_idx + AW'(1);
            if (pop) rd_idx <= rd_idx + AW'(1);
            count <= count + CW'(do_push) - CW'(pop);
        end
    end

    // Entry threshold guarantees the FIFO still holds the next beat during DATA
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= S_IDLE;
            axis_slave2_tvalid <= 1'b0;
            axis_slave2_tdata  <= '0;
            axis_slave2_tlast  <= 1'b0;
            wr_ptr             <= '0;
            wrap_irq           <= 1'b0;
            beat_cnt           <= '0;
            ring_lat           <= '0;
        end else begin
            wrap_irq <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!cfg_en) begin
                        wr_ptr <= '0;
                    end else if (count >= BURST_C) begin
                        state              <= S_HDR;
                        axis_slave2_tvalid <= 1'b1;
                        axis_slave2_tlast  <= 1'b0;
                        ring_lat           <= cfg_ring_beats;
                        axis_slave2_tdata  <= {32'h0,
                                               cfg_base_addr + {12'h0, wr_ptr, 4'h0},
                                               ep_bus_num, ep_dev_num, 3'b000, 8'h00, 4'hF, 4'hF,
                                               3'b010, 19'h0, LEN_DW};
                    end
                end
                S_HDR: begin
                    if (axis_slave2_tready) begin
                        state             <= S_DATA;
                        beat_cnt          <= '0;
                        axis_slave2_tdata <= mem[rd_idx];
                        axis_slave2_tlast <= (BURST_BEATS == 1);
                    end
                end
                S_DATA: begin
                    if (axis_slave2_tready) begin
                        if (axis_slave2_tlast) begin
                            state              <= S_IDLE;
                            axis_slave2_tvalid <= 1'b0;
                            axis_slave2_tlast  <= 1'b0;
                            axis_slave2_tdata  <= '0;
                            if (ptr_next == ring_lat) begin
                                wr_ptr   <= '0;
                                wrap_irq <= 1'b1;
                            end else begin
                                wr_ptr <= ptr_next;
                            end
                        end else begin
                            beat_cnt          <= beat_cnt + 16'd1;
                            axis_slave2_tdata <= mem[rd_idx + AW'(1)];
                            axis_slave2_tlast <= (beat_cnt + 16'd1 == LAST_IDX);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
